b_fsm: RTL and testbench
========================

B_FSM -- requirements
Module: b_fsm

Interface
REQ-001 Parameters: none; the state encoding is fixed by the package constants in REQ-026.
REQ-002 Ports SHALL appear in this positional order: y_out, x_in, clk, reset; debug ports (REQ-022) follow after reset.
REQ-003 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; forces the state to B immediately.
REQ-005 y_out  output  1  Mealy output, combinational from current state and x_in.
REQ-006 x_in  input  1  serial data input, sampled at each rising clk edge.

Function
REQ-007 The state register SHALL be 3 bits wide with encoding A=000, B=001, C=010, D=011, E=100.
REQ-008 y_out SHALL settle combinationally, within the same cycle, to any change of x_in or the state.
REQ-009 The next state SHALL be loaded on the rising clk edge while reset is low.
REQ-010 From A: x_in=1 -> y_out=1, next E; x_in=0 -> y_out=0, next A.
REQ-011 From B: x_in=1 -> y_out=1, next E; x_in=0 -> y_out=0, next B.
REQ-012 From C: x_in=1 -> y_out=1, next A; x_in=0 -> y_out=0, next B.
REQ-013 From D: x_in=1 -> y_out=1, next C; x_in=0 -> y_out=0, next B.
REQ-014 From E: x_in=1 -> y_out=0, next D; x_in=0 -> y_out=1, next A.
REQ-015 Unused encodings 101, 110 and 111 SHALL drive y_out=0 and a next state of B for either x_in value (self-recovery).
REQ-016 An x_in change between clock edges SHALL affect y_out immediately but SHALL NOT affect the state until the next rising edge.

Reset
REQ-017 While reset=1 the state SHALL be B regardless of clk.
REQ-018 While reset=1, y_out SHALL follow B's output: 0 for x_in=0, 1 for x_in=1.
REQ-019 Reset asserted mid-sequence SHALL override any pending transition, with no clock edge required.
REQ-020 After reset deasserts, the first rising clk edge SHALL apply the normal B transition.
REQ-021 No other storage exists; the design SHALL have no reset-dependent latency.

Configuration
REQ-022 With macro B_FSM_DEBUG_EN defined, ports state_out (output, 3 bits, current state) and illegal_state (output, 1 bit, high when the state is 101, 110 or 111) SHALL be added after reset.
REQ-023 Without B_FSM_DEBUG_EN, the port list SHALL be exactly the four ports of REQ-002, and the functional behaviour SHALL be identical.
REQ-024 Under reset, state_out SHALL read 001 and illegal_state SHALL read 0.

Structure
REQ-025 The design SHALL be a single module with no sub-modules.
REQ-026 Package b_fsm_pkg SHALL hold the state type (3-bit enum) and the constants ST_A through ST_E plus ST_RESET=ST_B.
REQ-027 The design SHALL use a separate sequential state process and a combinational next-state/output process, with a default assignment in every branch.

Verification
REQ-028 Reset pulse, x_in=0, several clk edges -> state remains B, y_out=0 throughout.
REQ-029 After reset, hold x_in=1 -> y_out sequence per state B,E,D,C,A,E,D = 1,0,1,1,1,0,1.
REQ-030 Enter E, then x_in=0 -> y_out=1 before the edge; next state A, then y_out=0.
REQ-031 Enter D, assert reset between clk edges -> state B immediately with no clk edge, y_out tracks x_in.
REQ-032 Toggle x_in mid-cycle in state C -> y_out flips 1/0 without a state change until the edge.
REQ-033 With B_FSM_DEBUG_EN defined, force the state to 110 -> illegal_state=1, y_out=0; next edge -> state_out=001.

Source files
------------

// File: rtl/b_fsm_pkg.sv
// Shared types and constants for the b_fsm serial Mealy machine.
// Holds the 3-bit state encoding, the reset state and a helper that flags unused encodings.
package b_fsm_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'b000,
        ST_B = 3'b001,
        ST_C = 3'b010,
        ST_D = 3'b011,
        ST_E = 3'b100
    } state_t;

    localparam state_t ST_RESET = ST_B;

    // Encodings 101, 110 and 111 are never reached in normal operation.
    function automatic logic is_illegal(input logic [2:0] s);
        return s[2] && (s[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/b_fsm_if.sv
// Serial data/result bundle for b_fsm.
// The driver side owns x_in; the FSM side produces y_out.
interface b_fsm_if;

    logic x_in;
    logic y_out;

    modport master (output x_in, input  y_out);
    modport slave  (input  x_in, output y_out);

endinterface

// File: rtl/b_fsm.sv
// Five-state Mealy FSM on a serial input; y_out is combinational from state and x_in.
// Define B_FSM_DEBUG_EN to add the state_out and illegal_state observation ports.
//
// state | meaning
// A     | 000, idle after a completed pattern
// B     | 001, reset / recovery state
// C     | 010, reached from D on x_in=1
// D     | 011, reached from E on x_in=1
// E     | 100, first 1 seen from A or B
module b_fsm
    import b_fsm_pkg::*;
(
    output logic       y_out,
    input  logic       x_in,
    input  logic       clk,
    input  logic       reset
`ifdef B_FSM_DEBUG_EN
    ,
    output logic [2:0] state_out,
    output logic       illegal_state
`endif
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings fall into default and steer back to B.
    always_comb begin
        state_d = ST_RESET;
        case (state_q)
            ST_A:    state_d = x_in ? ST_E : ST_A;
            ST_B:    state_d = x_in ? ST_E : ST_B;
            ST_C:    state_d = x_in ? ST_A : ST_B;
            ST_D:    state_d = x_in ? ST_C : ST_B;
            ST_E:    state_d = x_in ? ST_D : ST_A;
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        y_out = 1'b0;
        case (state_q)
            ST_A:    y_out = x_in;
            ST_B:    y_out = x_in;
            ST_C:    y_out = x_in;
            ST_D:    y_out = x_in;
            ST_E:    y_out = ~x_in;
            default: y_out = 1'b0;
        endcase
    end

`ifdef B_FSM_DEBUG_EN
    assign state_out     = state_q;
    assign illegal_state = is_illegal(state_q);
`endif

endmodule

// File: tb/tb_b_fsm.sv
// Directed self-checking bench for b_fsm with a queue-based scoreboard of expected outputs.
// Define B_FSM_DEBUG_EN to also exercise the debug ports and illegal-state recovery.
module tb_b_fsm;

    logic clk;
    logic reset;

    b_fsm_if bus ();

`ifdef B_FSM_DEBUG_EN
    logic [2:0] state_out;
    logic       illegal_state;
`endif

    b_fsm dut (
        .y_out         (bus.y_out),
        .x_in          (bus.x_in),
        .clk           (clk),
        .reset         (reset)
`ifdef B_FSM_DEBUG_EN
        ,
        .state_out     (state_out),
        .illegal_state (illegal_state)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables indexed by the 3-bit state.
    logic [2:0] nxt_x0 [0:7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1};
    logic [2:0] nxt_x1 [0:7] = '{3'd4, 3'd4, 3'd0, 3'd2, 3'd3, 3'd1, 3'd1, 3'd1};
    logic       out_x0 [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       out_x1 [0:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [2:0] model_st;
    logic       exp_y_q [$];
    logic [2:0] exp_st_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic model_y(input logic [2:0] s, input logic x);
        return x ? out_x1[s] : out_x0[s];
    endfunction

    task automatic push_expect();
        exp_y_q.push_back(model_y(model_st, bus.x_in));
        exp_st_q.push_back(model_st);
    endtask

    task automatic pop_check(input string tag);
        logic       ey;
        logic [2:0] es;
        ey = exp_y_q.pop_front();
        es = exp_st_q.pop_front();
        n_checks++;
        assert (bus.y_out === ey) else begin
            n_errors++;
            $error("FAIL %s y_out observed=%0b expected=%0b", tag, bus.y_out, ey);
        end
        n_checks++;
        assert (dut.state_q === es) else begin
            n_errors++;
            $error("FAIL %s state observed=%03b expected=%03b", tag, dut.state_q, es);
        end
    endtask

    task automatic set_x(input logic x, input string tag);
        bus.x_in = x;
        push_expect();
        #1;
        pop_check(tag);
    endtask

    task automatic clock_edge(input string tag);
        @(posedge clk);
        if (!reset) model_st = bus.x_in ? nxt_x1[model_st] : nxt_x0[model_st];
        push_expect();
        #1;
        pop_check(tag);
    endtask

    initial begin
        reset    = 1'b1;
        bus.x_in = 1'b0;
        model_st = 3'b001;
        #2;
        push_expect();
        pop_check("rst_x0");
        set_x(1'b1, "rst_x1");
        set_x(1'b0, "rst_x0b");
        repeat (3) clock_edge("rst_hold");

        // release reset away from the edge; B must hold with x_in=0
        @(negedge clk);
        reset = 1'b0;
        #1;
        push_expect();
        pop_check("rst_rel");
        repeat (3) clock_edge("b_idle");

        // x_in=1 walk: B,E,D,C,A,E,D -> 1,0,1,1,1,0,1
        set_x(1'b1, "walk_B");
        clock_edge("walk_E");
        clock_edge("walk_D");
        clock_edge("walk_C");

        // mid-cycle toggles in C change y_out only
        set_x(1'b0, "c_tog0");
        set_x(1'b1, "c_tog1");
        set_x(1'b0, "c_tog0b");
        set_x(1'b1, "c_tog1b");
        clock_edge("walk_A");
        clock_edge("walk_E2");

        // E with x_in=0 outputs 1, then moves to A
        set_x(1'b0, "e_x0");
        clock_edge("e_to_a");

        // reach D then reset between edges
        set_x(1'b1, "a_x1");
        clock_edge("to_E");
        clock_edge("to_D");
        #2;
        reset    = 1'b1;
        model_st = 3'b001;
        #1;
        push_expect();
        pop_check("rst_async");
        set_x(1'b0, "rst_trk0");
        set_x(1'b1, "rst_trk1");
        @(negedge clk);
        reset = 1'b0;
        #1;
        push_expect();
        pop_check("rst_rel2");
        clock_edge("post_rst_E");

`ifdef B_FSM_DEBUG_EN
        n_checks++;
        assert (state_out === model_st) else begin
            n_errors++;
            $error("FAIL dbg_state observed=%03b expected=%03b", state_out, model_st);
        end
        @(negedge clk);
        force dut.state_q = b_fsm_pkg::state_t'(3'b110);
        #1;
        n_checks++;
        assert (illegal_state === 1'b1) else begin
            n_errors++;
            $error("FAIL dbg_illegal observed=%0b expected=1", illegal_state);
        end
        n_checks++;
        assert (bus.y_out === 1'b0) else begin
            n_errors++;
            $error("FAIL dbg_illegal_y observed=%0b expected=0", bus.y_out);
        end
        release dut.state_q;
        @(posedge clk);
        #1;
        model_st = 3'b001;
        n_checks++;
        assert (state_out === 3'b001) else begin
            n_errors++;
            $error("FAIL dbg_recover observed=%03b expected=001", state_out);
        end
        n_checks++;
        assert (illegal_state === 1'b0) else begin
            n_errors++;
            $error("FAIL dbg_recover_flag observed=%0b expected=0", illegal_state);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
